// File: rtl/cla_chunk_seq.sv
// Wide adder sequencer: feeds 5-bit slices, LSB first, through an
// external registered 5-bit CLA stage and chains the carry between passes.
module cla_chunk_seq #(
    parameter int NCHUNK = 4,
    parameter int LAT    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_in,
    input  logic [5*NCHUNK-1:0]   A_in,
    input  logic [5*NCHUNK-1:0]   B_in,
    input  logic                  Cin_in,
    input  logic [4:0]            cla_S_in,
    input  logic                  cla_Cout_in,
    output logic [4:0]            cla_A_out,
    output logic [4:0]            cla_B_out,
    output logic                  cla_Cin_out,
    output logic [5*NCHUNK-1:0]   S_out,
    output logic                  Cout_out,
    output logic                  ovf_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int W  = 5 * NCHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state, state_d;
    logic [CW-1:0]  chunk, chunk_d;
    logic [WW-1:0]  wcnt, wcnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   s_acc, s_acc_d;
    logic           carry, carry_d;
    logic [4:0]     cla_a_d, cla_b_d;
    logic           cla_cin_d;
    logic [W-1:0]   s_d;
    logic           cout_d, ovf_d, busy_d, done_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            chunk       <= '0;
            wcnt        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_acc       <= '0;
            carry       <= 1'b0;
            cla_A_out   <= '0;
            cla_B_out   <= '0;
            cla_Cin_out <= 1'b0;
            S_out       <= '0;
            Cout_out    <= 1'b0;
            ovf_out     <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
        end else begin
            state       <= state_d;
            chunk       <= chunk_d;
            wcnt        <= wcnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_acc       <= s_acc_d;
            carry       <= carry_d;
            cla_A_out   <= cla_a_d;
            cla_B_out   <= cla_b_d;
            cla_Cin_out <= cla_cin_d;
            S_out       <= s_d;
            Cout_out    <= cout_d;
            ovf_out     <= ovf_d;
            busy_out    <= busy_d;
            done_out    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        chunk_d   = chunk;
        wcnt_d    = wcnt;
        a_d       = a_q;
        b_d       = b_q;
        s_acc_d   = s_acc;
        carry_d   = carry;
        cla_a_d   = cla_A_out;
        cla_b_d   = cla_B_out;
        cla_cin_d = cla_Cin_out;
        s_d       = S_out;
        cout_d    = Cout_out;
        ovf_d     = ovf_out;
        busy_d    = busy_out;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (start_in) begin
                    a_d       = A_in;
                    b_d       = B_in;
                    s_acc_d   = '0;
                    chunk_d   = '0;
                    wcnt_d    = '0;
                    cla_a_d   = A_in[4:0];
                    cla_b_d   = B_in[4:0];
                    cla_cin_d = Cin_in;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (wcnt != WW'(LAT)) begin
                    wcnt_d = wcnt + 1'b1;
                end else begin
                    s_acc_d[chunk*5 +: 5] = cla_S_in;
                    carry_d = cla_Cout_in;
                    if (chunk != CW'(NCHUNK - 1)) begin
                        chunk_d   = chunk + 1'b1;
                        wcnt_d    = '0;
                        cla_a_d   = a_q[chunk_d*5 +: 5];
                        cla_b_d   = b_q[chunk_d*5 +: 5];
                        cla_cin_d = cla_Cout_in;
                    end else begin
                        // Overflow judged on the completed sum, not S_out.
                        s_d       = s_acc_d;
                        cout_d    = cla_Cout_in;
                        ovf_d     = (a_q[W-1] == b_q[W-1]) &&
                                    (s_acc_d[W-1] != a_q[W-1]);
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                        cla_a_d   = '0;
                        cla_b_d   = '0;
                        cla_cin_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cla_chunk_seq.sv
// Bench for cla_chunk_seq driving a two-register 5-bit adder model,
// with a queue of expected results checked on each done pulse.
module tb_cla_chunk_seq;

    logic        CLK;
    logic        RST;
    logic        start_in;
    logic [19:0] A_in, B_in;
    logic        Cin_in;
    logic [4:0]  cla_S_in;
    logic        cla_Cout_in;
    logic [4:0]  cla_A_out, cla_B_out;
    logic        cla_Cin_out;
    logic [19:0] S_out;
    logic        Cout_out, ovf_out, busy_out, done_out;

    typedef struct {
        logic [19:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    cla_chunk_seq #(.NCHUNK(4), .LAT(2)) dut (
        .CLK(CLK), .RST(RST), .start_in(start_in),
        .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in),
        .cla_S_in(cla_S_in), .cla_Cout_in(cla_Cout_in),
        .cla_A_out(cla_A_out), .cla_B_out(cla_B_out),
        .cla_Cin_out(cla_Cin_out), .S_out(S_out),
        .Cout_out(Cout_out), .ovf_out(ovf_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered adder stage: input register, then output register.
    logic [4:0] m_a, m_b;
    logic       m_c;
    always @(posedge CLK) begin
        m_a <= cla_A_out;
        m_b <= cla_B_out;
        m_c <= cla_Cin_out;
        {cla_Cout_in, cla_S_in} <= {1'b0, m_a} + {1'b0, m_b} + 6'(m_c);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && done_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done_out), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("S_out", 32'(S_out), 32'(e.s));
                chk("Cout_out", 32'(Cout_out), 32'(e.c));
                chk("ovf_out", 32'(ovf_out), 32'(e.v));
            end
        end
    end

    function automatic exp_t model(input logic [19:0] a, b,
                                   input logic cin);
        exp_t e;
        logic [20:0] t;
        t   = {1'b0, a} + {1'b0, b} + 21'(cin);
        e.s = t[19:0];
        e.c = t[20];
        e.v = (a[19] == b[19]) && (t[19] != a[19]);
        return e;
    endfunction

    // Runs one job from the accept edge to the done edge, checking
    // busy/done timing and each slice driven to the adder.
    task automatic job(input logic [19:0] a, b, input logic cin,
                       input int gap);
        logic [63:0] m, lo;
        int          s;
        sb.push_back(model(a, b, cin));
        A_in = a; B_in = b; Cin_in = cin; start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge CLK);
            chk("busy", 32'(busy_out), 32'(k < 12));
            chk("done", 32'(done_out), 32'(k == 12));
            if (k % 3 == 0 && k < 12) begin
                s  = 5 * (k / 3);
                m  = (64'd1 << s) - 64'd1;
                lo = ({44'd0, a} & m) + ({44'd0, b} & m) + 64'(cin);
                chk("slice_cin", 32'(cla_Cin_out), 32'((lo >> s) & 1));
                chk("slice_a", 32'(cla_A_out), 32'((a >> s) & 20'h1f));
                chk("slice_b", 32'(cla_B_out), 32'((b >> s) & 20'h1f));
            end
        end
        repeat (gap) @(negedge CLK);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1; start_in = 1'b0;
        A_in = '0; B_in = '0; Cin_in = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_S", 32'(S_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_cla", 32'({cla_A_out, cla_B_out, cla_Cin_out}), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        job(20'h12345, 20'h0ABCD, 1'b0, 1);
        chk("hold_S", 32'(S_out), 32'h1CF12);
        job(20'hFFFFF, 20'h00001, 1'b0, 1);
        job(20'h7FFFF, 20'h00000, 1'b1, 2);
        chk("hold_ovf", 32'(ovf_out), 32'd1);

        // Abort: ignored start at edge 4, reset at edge 6.
        A_in = 20'h11111; B_in = 20'h22222; Cin_in = 1'b0;
        start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        repeat (3) @(negedge CLK);
        A_in = 20'h0F0F0; B_in = 20'h0A0A0; start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        chk("ign_a", 32'(cla_A_out), 32'((20'h11111 >> 5) & 20'h1f));
        chk("ign_b", 32'(cla_B_out), 32'((20'h22222 >> 5) & 20'h1f));
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_S", 32'(S_out), 32'd0);
        chk("abort_flags", 32'({Cout_out, ovf_out, busy_out}), 32'd0);
        chk("abort_cla", 32'({cla_A_out, cla_B_out, cla_Cin_out}), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("abort_nodone", 32'(done_out), 32'd0);
        end
        job(20'h00003, 20'h00004, 1'b0, 0);
        chk("fresh_S", 32'(S_out), 32'h00007);
        repeat (2) @(negedge CLK);

        // Back-to-back with start held through the done cycle.
        sb.push_back(model(20'h00010, 20'h00020, 1'b0));
        A_in = 20'h00010; B_in = 20'h00020; Cin_in = 1'b0;
        start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        repeat (11) @(negedge CLK);
        sb.push_back(model(20'hFFFFF, 20'hFFFFF, 1'b1));
        A_in = 20'hFFFFF; B_in = 20'hFFFFF; Cin_in = 1'b1;
        start_in = 1'b1;
        for (int k = 12; k <= 25; k++) begin
            @(negedge CLK);
            if (k == 13) start_in = 1'b0;
            chk("b2b_done", 32'(done_out), 32'(k == 12 || k == 25));
            if (k == 12) chk("b2b_S1", 32'(S_out), 32'h00030);
            if (k == 13) chk("b2b_busy", 32'(busy_out), 32'd1);
        end
        chk("b2b_S2", 32'(S_out), 32'hFFFFF);
        chk("b2b_C2", 32'(Cout_out), 32'd1);

        for (int n = 0; n < 500; n++) begin
            job(20'($urandom), 20'($urandom), 1'($urandom),
                int'($urandom_range(0, 4)));
        end

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
